// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: state encoding,
// coin denominations, default prices and widths.
package vend_pkg;

    localparam int unsigned DEF_CREDIT_W    = 8;
    localparam int unsigned DEF_MAX_CREDIT  = 99;
    localparam int unsigned DEF_PRICE0      = 15;
    localparam int unsigned DEF_PRICE1      = 20;
    localparam int unsigned DEF_PRICE2      = 25;
    localparam int unsigned DEF_PRICE3      = 30;
    localparam int unsigned DEF_TIMEOUT_CYC = 1000;

    localparam int unsigned COIN_W  = 5;
    localparam int unsigned ITEM_W  = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [COIN_W-1:0] COIN_1  = 5'd1;
    localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
    localparam logic [COIN_W-1:0] COIN_10 = 5'd10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_e;

    // Payload toward the dispenser actuator
    typedef struct packed {
        logic              valid;
        logic [ITEM_W-1:0] item;
    } dispense_t;

    // Only the three real denominations are ever credited
    function automatic logic f_coin_legal(input logic [COIN_W-1:0] value);
        return (value == COIN_1) || (value == COIN_5) || (value == COIN_10);
    endfunction

endpackage

// File: rtl/change_gen.sv
// Change coin generator: greedy 10/5/1 denomination select with registered
// valid/coin outputs. Outputs are computed from the controller's next-cycle
// credit, so a coin not taken by the hopper is naturally held stable.
module change_gen
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = DEF_CREDIT_W
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_active_nxt,
    input  logic [CREDIT_W-1:0] i_credit_nxt,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [COIN_W-1:0]   o_coin,
    output logic                o_fire_c
);

    logic              r_valid;
    logic [COIN_W-1:0] r_coin;
    logic [COIN_W-1:0] w_coin_nxt;
    logic              w_valid_nxt;

    // Largest denomination not exceeding the remaining credit
    always_comb begin
        w_coin_nxt  = '0;
        w_valid_nxt = i_active_nxt && (i_credit_nxt != '0);
        if (w_valid_nxt) begin
            if (i_credit_nxt >= CREDIT_W'(COIN_10)) begin
                w_coin_nxt = COIN_10;
            end else if (i_credit_nxt >= CREDIT_W'(COIN_5)) begin
                w_coin_nxt = COIN_5;
            end else begin
                w_coin_nxt = COIN_1;
            end
        end
    end

    // Register the offered coin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_coin  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_coin  <= w_coin_nxt;
        end
    end

    assign o_valid  = r_valid;
    assign o_coin   = r_coin;
    assign o_fire_c = r_valid && i_ready;

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: accumulates coin credit, checks selections
// against item prices, pulses a dispense, then pays out change over a
// valid/ready handshake.
// Optional macro VEND_TIMEOUT_EN: auto-refund after TIMEOUT_CYC idle cycles
// in CREDIT.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
    parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int unsigned PRICE0     = DEF_PRICE0,
    parameter int unsigned PRICE1     = DEF_PRICE1,
    parameter int unsigned PRICE2     = DEF_PRICE2,
    parameter int unsigned PRICE3     = DEF_PRICE3
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COIN_W-1:0]   coin_value,
    input  logic                coin_valid,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel_item,
    input  logic                cancel,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                dispense_valid,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                change_valid,
    output logic [COIN_W-1:0]   change_coin,
    output logic [STATE_W-1:0]  state
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    vend_state_e         r_state;
    vend_state_e         w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_coin_reject;
    logic                w_coin_reject_nxt;
    logic                r_insufficient;
    logic                w_insufficient_nxt;
    dispense_t           r_disp;
    dispense_t           w_disp_nxt;

    logic                w_in_entry;
    logic                w_cancel_eff;
    logic                w_sel_ok;
    logic                w_sel_insuf;
    logic                w_coin_ok;
    logic                w_fire;
    logic                w_timeout;
    logic                w_chg_active_nxt;
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W-1:0] w_chg_left;
    logic [SUM_W-1:0]    w_sum;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_idle_cnt;

    assign w_timeout = (r_state == ST_CREDIT) &&
                       (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Idle counter: runs only in CREDIT, cleared by any customer activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state != ST_CREDIT) || coin_valid || sel_valid || cancel) begin
            r_idle_cnt <= '0;
        end else if (!w_timeout) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Price lookup for the selected item
    always_comb begin
        w_price = CREDIT_W'(PRICE0);
        case (sel_item)
            2'd0:    w_price = CREDIT_W'(PRICE0);
            2'd1:    w_price = CREDIT_W'(PRICE1);
            2'd2:    w_price = CREDIT_W'(PRICE2);
            default: w_price = CREDIT_W'(PRICE3);
        endcase
    end

    // Event decode with priority cancel > selection > coin
    always_comb begin
        w_in_entry   = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
        w_cancel_eff = (r_state == ST_CREDIT) && (cancel || w_timeout);
        w_sel_ok     = (r_state == ST_CREDIT) && sel_valid && !w_cancel_eff &&
                       (r_credit >= w_price);
        w_sel_insuf  = w_in_entry && sel_valid && !w_cancel_eff && !w_sel_ok;
        w_sum        = SUM_W'(r_credit) + SUM_W'(coin_value);
        w_coin_ok    = w_in_entry && coin_valid && !w_cancel_eff && !w_sel_ok &&
                       f_coin_legal(coin_value) && (w_sum <= SUM_W'(MAX_CREDIT));
        w_chg_left   = r_credit - CREDIT_W'(change_coin);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_ok) begin
                    w_state_nxt = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (w_cancel_eff) begin
                    w_state_nxt = ST_CHANGE;
                end else if (w_sel_ok) begin
                    w_state_nxt = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if ((r_credit == '0) || (w_fire && (w_chg_left == '0))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for credit and the pulse outputs
    always_comb begin
        w_credit_nxt       = r_credit;
        w_coin_reject_nxt  = coin_valid && !w_coin_ok;
        w_insufficient_nxt = w_sel_insuf;
        w_disp_nxt         = '0;
        if (w_coin_ok) begin
            w_credit_nxt = CREDIT_W'(w_sum);
        end
        if (w_sel_ok) begin
            w_credit_nxt    = r_credit - w_price;
            w_disp_nxt.valid = 1'b1;
            w_disp_nxt.item  = sel_item;
        end
        if ((r_state == ST_CHANGE) && w_fire) begin
            w_credit_nxt = w_chg_left;
        end
    end

    // Output and credit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit       <= '0;
            r_coin_reject  <= 1'b0;
            r_insufficient <= 1'b0;
            r_disp         <= '0;
        end else begin
            r_credit       <= w_credit_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
            r_insufficient <= w_insufficient_nxt;
            r_disp         <= w_disp_nxt;
        end
    end

    assign w_chg_active_nxt = (w_state_nxt == ST_CHANGE);

    // Change payout toward the hopper
    change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_active_nxt (w_chg_active_nxt),
        .i_credit_nxt (w_credit_nxt),
        .i_ready      (change_ready),
        .o_valid      (change_valid),
        .o_coin       (change_coin),
        .o_fire_c     (w_fire)
    );

    assign credit         = r_credit;
    assign coin_reject    = r_coin_reject;
    assign insufficient   = r_insufficient;
    assign dispense_valid = r_disp.valid;
    assign dispense_item  = r_disp.item;
    assign state          = r_state;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_vend_controller;

    logic       clk;
    logic       rst_n;
    logic [4:0] coin_value;
    logic       coin_valid;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       change_ready;
    logic [7:0] credit;
    logic       coin_reject;
    logic       insufficient;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [4:0] change_coin;
    logic [1:0] state;

    vend_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_value     (coin_value),
        .coin_valid     (coin_valid),
        .sel_valid      (sel_valid),
        .sel_item       (sel_item),
        .cancel         (cancel),
        .change_ready   (change_ready),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .insufficient   (insufficient),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_coin    (change_coin),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: machine phase (0 idle,1 credit,2 dispense,3 change) and credit
    int m_state  = 0;
    int m_credit = 0;
    int e_rej    = 0;
    int e_ins    = 0;
    int e_dv     = 0;
    int e_di     = 0;
    int prices [4] = '{15, 20, 25, 30};
    int denoms [3] = '{10, 5, 1};
    int coin_tbl [8] = '{1, 5, 10, 1, 5, 10, 3, 0};

    function automatic int greedy(input int c);
        for (int i = 0; i < 3; i++) begin
            if (c >= denoms[i]) return denoms[i];
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ecv;
        ecv = (m_state == 3 && m_credit > 0) ? 1 : 0;
        check({tag, ".credit"},       32'(credit),       32'(m_credit));
        check({tag, ".state"},        32'(state),        32'(m_state));
        check({tag, ".coin_reject"},  32'(coin_reject),  32'(e_rej));
        check({tag, ".insufficient"}, 32'(insufficient), 32'(e_ins));
        check({tag, ".disp_valid"},   32'(dispense_valid), 32'(e_dv));
        if (e_dv != 0) check({tag, ".disp_item"}, 32'(dispense_item), 32'(e_di));
        check({tag, ".chg_valid"},    32'(change_valid), 32'(ecv));
        if (ecv != 0) check({tag, ".chg_coin"}, 32'(change_coin), 32'(greedy(m_credit)));
    endtask

    // One clock of stimulus, model update and output check
    task automatic step(input string tag, input bit cv, input int val, input bit sv,
                        input int item, input bit cn, input bit rdy);
        int  s;
        int  c;
        int  ns;
        int  nc;
        bit  sold;
        @(negedge clk);
        coin_valid   = cv;
        coin_value   = 5'(val);
        sel_valid    = sv;
        sel_item     = 2'(item);
        cancel       = cn;
        change_ready = rdy;
        s = m_state; c = m_credit; ns = s; nc = c; sold = 1'b0;
        e_rej = 0; e_ins = 0; e_dv = 0; e_di = 0;
        if (s <= 1) begin
            if (s == 1 && cn) begin
                ns = 3;
                e_rej = cv ? 1 : 0;
            end else begin
                if (sv) begin
                    if (s == 1 && c >= prices[item]) begin
                        sold = 1'b1; nc = c - prices[item]; ns = 2; e_dv = 1; e_di = item;
                    end else begin
                        e_ins = 1;
                    end
                end
                if (cv) begin
                    if (!sold && (val == 1 || val == 5 || val == 10) && (c + val <= 99)) begin
                        nc = c + val;
                        if (s == 0) ns = 1;
                    end else begin
                        e_rej = 1;
                    end
                end
            end
        end else if (s == 2) begin
            e_rej = cv ? 1 : 0;
            ns = (c > 0) ? 3 : 0;
        end else begin
            e_rej = cv ? 1 : 0;
            if (c == 0) ns = 0;
            else if (rdy) begin
                nc = c - greedy(c);
                if (nc == 0) ns = 0;
            end
        end
        m_state = ns; m_credit = nc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic coin(input string tag, input int v);
        step(tag, 1'b1, v, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input bit rdy);
        step(tag, 1'b0, 0, 1'b0, 0, 1'b0, rdy);
    endtask

    initial begin
        rst_n = 1'b0; coin_value = '0; coin_valid = 1'b0; sel_valid = 1'b0;
        sel_item = '0; cancel = 1'b0; change_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Exact payment: 10+5 then item 0, no change
        coin("s1_c10", 10);
        coin("s1_c5", 5);
        step("s1_sel0", 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
        idle("s1_done", 1'b1);
        idle("s1_idle", 1'b1);

        // 30 credit, item 1, one 10 change coin
        coin("s2_c10a", 10);
        coin("s2_c10b", 10);
        coin("s2_c10c", 10);
        step("s2_sel1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
        idle("s2_disp", 1'b1);
        idle("s2_chg", 1'b1);
        idle("s2_idle", 1'b1);

        // Credit 7, cancel, hopper stalls 3 cycles then drains 5,1,1
        coin("s3_c5", 5);
        coin("s3_c1a", 1);
        coin("s3_c1b", 1);
        step("s3_cancel", 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle("s3_stall", 1'b0);
        for (int i = 0; i < 4; i++) idle("s3_drain", 1'b1);

        // Ceiling: 95 then 10 rejected, 1 accepted
        for (int i = 0; i < 9; i++) coin("s4_fill", 10);
        coin("s4_c5", 5);
        coin("s4_over", 10);
        coin("s4_c1", 1);
        step("s4_cancel", 1'b0, 0, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) idle("s4_drain", 1'b1);

        // Illegal denomination, idle selection and idle cancel
        coin("s5_bad", 3);
        step("s5_idle_sel", 1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        step("s5_idle_cancel", 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);

        // Insufficient with same-cycle coin, then coin during dispense
        coin("s6_c10", 10);
        step("s6_sel3_c5", 1'b1, 5, 1'b1, 3, 1'b0, 1'b0);
        step("s6_sel0", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
        coin("s6_disp_coin", 5);
        idle("s6_idle", 1'b0);

        // Cancel beats same-cycle selection and coin
        coin("s7_c10", 10);
        coin("s7_c10b", 10);
        step("s7_cancel_all", 1'b1, 5, 1'b1, 0, 1'b1, 1'b0);
        coin("s7_chg_coin", 1);
        for (int i = 0; i < 3; i++) idle("s7_drain", 1'b1);

        // Asynchronous reset during change with credit 16
        coin("s8_c10", 10);
        coin("s8_c5", 5);
        coin("s8_c1", 1);
        step("s8_cancel", 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_state = 0; m_credit = 0; e_rej = 0; e_ins = 0; e_dv = 0; e_di = 0;
        check_all("s8_async_rst");
        check("s8_chg_coin_rst", 32'(change_coin), 32'd0);
        check("s8_disp_item_rst", 32'(dispense_item), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("s8_after", 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            step("rnd",
                 ($urandom % 3) == 0,
                 coin_tbl[$urandom % 8],
                 ($urandom % 6) == 0,
                 int'($urandom % 4),
                 ($urandom % 20) == 0,
                 ($urandom % 2) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
